store_v: RTL and testbench

STORE_V -- requirements
Module: store_v

---
 rtl/store_v_pkg.sv | 17 +
 rtl/store_v.sv | 108 ++++++++++
 tb/tb_store_v.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_v_pkg.sv
// Shared tinyml memory-side definitions: DRAM address/length widths and the
// transfer state encoding used by both the vector store and vector load blocks.
package store_v_pkg;

  localparam int unsigned DramAddrW = 24;
  localparam int unsigned LenW      = 10;
  // One bit wider than length so a count of 1023+1 never aliases.
  localparam int unsigned CountW    = LenW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTile,
    StWriting,
    StDone
  } xfer_state_e;

endpackage

// File: rtl/store_v.sv
// Vector store: takes tiles of ELEM_COUNT elements and writes the first `length`
// elements to consecutive DRAM addresses, one write per accepted memory cycle.
module store_v
  import store_v_pkg::*;
#(
  parameter int unsigned TILE_WIDTH = 256,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ELEM_COUNT = TILE_WIDTH / DATA_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  input  logic [DramAddrW-1:0]                  dram_addr,
  input  logic [LenW-1:0]                       length,
  input  logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] tile_in,
  input  logic                                  tile_valid,
  output logic                                  tile_ready,
  output logic                                  busy,
  output logic                                  valid_out,
  output logic                                  mem_we,
  output logic [DramAddrW-1:0]                  mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_ready
);

  localparam int unsigned IdxW = (ELEM_COUNT > 1) ? $clog2(ELEM_COUNT) : 1;

  xfer_state_e                           state_q, state_d;
  logic [DramAddrW-1:0]                  addr_q, addr_d;
  logic [LenW-1:0]                       len_q, len_d;
  logic [CountW-1:0]                     count_q, count_d;
  logic [CountW-1:0]                     count_inc;
  logic [IdxW-1:0]                       idx_q, idx_d;
  logic [ELEM_COUNT-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    count_d   = count_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    count_inc = count_q + CountW'(1);

    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          addr_d  = dram_addr;
          len_d   = length;
          count_d = '0;
          state_d = (length == '0) ? StDone : StWaitTile;
        end
      end
      StWaitTile: begin
        if (tile_valid) begin
          buf_d   = tile_in;
          idx_d   = '0;
          state_d = StWriting;
        end
      end
      StWriting: begin
        // Everything advances only on an accepted write; a stall holds all state.
        if (mem_ready) begin
          addr_d  = addr_q + DramAddrW'(1);
          idx_d   = idx_q + IdxW'(1);
          count_d = count_inc;
          if (count_inc == CountW'(len_q)) begin
            state_d = StDone;
          end else if (idx_q == IdxW'(ELEM_COUNT - 1)) begin
            state_d = StWaitTile;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  assign tile_ready = (state_q == StWaitTile);
  assign busy       = (state_q != StIdle);
  assign valid_out  = (state_q == StDone);
  assign mem_we     = (state_q == StWriting);
  assign mem_addr   = addr_q;
  assign mem_wdata  = buf_q[idx_q];

endmodule

// File: tb/tb_store_v.sv
// Bench for store_v: directed vector table, stall/reset sequences and random
// transfers checked against a list-of-writes reference model.
module tb_store_v;

  localparam int EC = 32;
  localparam int DW = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   valid_in;
  logic [23:0]            dram_addr;
  logic [9:0]             length;
  logic [EC-1:0][DW-1:0]  tile_in;
  logic                   tile_valid;
  logic                   tile_ready;
  logic                   busy;
  logic                   valid_out;
  logic                   mem_we;
  logic [23:0]            mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_ready;

  always #5 clk = ~clk;

  store_v #(
    .TILE_WIDTH(256),
    .DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .dram_addr (dram_addr),
    .length    (length),
    .tile_in   (tile_in),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .busy      (busy),
    .valid_out (valid_out),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Source element stream: tile k element j is src[k*EC + j].
  byte unsigned src[1056];

  // Observed activity, gathered at the falling edge.
  int          cyc = 0;
  int          hs_cnt, tr_cnt, vo_cnt, vo_cyc, vi_cyc, last_we_cyc, stall_seen;
  logic [23:0] wa_q[$];
  logic [7:0]  wd_q[$];

  // Stimulus knobs.
  int          ready_pct  = 100;
  int          tvalid_pct = 100;
  bit          spurious   = 1'b0;
  int          stall_at   = -1;
  int          stall_left = 0;
  bit          hold_chk   = 1'b0;
  logic [23:0] hold_addr;
  logic [7:0]  hold_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mem_we && mem_ready) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
        last_we_cyc = cyc;
      end
      if (mem_we && !mem_ready) begin
        stall_seen++;
        if (hold_chk) begin
          check("stall_addr_hold", mem_addr, hold_addr);
          check("stall_data_hold", mem_wdata, hold_data);
        end
      end
      if (tile_ready && tile_valid) hs_cnt++;
      if (tile_ready) tr_cnt++;
      if (valid_out) begin
        vo_cnt++;
        vo_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (stall_at >= 0 && wa_q.size() == stall_at && stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = ($urandom_range(0, 99) < ready_pct);
    end
    tile_valid = ($urandom_range(0, 99) < tvalid_pct);
    for (int j = 0; j < EC; j++) begin
      int k;
      k = hs_cnt * EC + j;
      tile_in[j] = (k < 1056) ? src[k] : 8'h00;
    end
    if (spurious && busy) begin
      valid_in  = ($urandom_range(0, 3) == 0);
      dram_addr = 24'($urandom);
      length    = 10'($urandom);
    end else begin
      valid_in = 1'b0;
    end
  endtask

  // exp_lat < 0 skips the latency check (random handshaking).
  task automatic run_xfer(input string tag, input logic [23:0] base, input int len,
                          input int exp_hs, input int exp_lat, input logic [23:0] exp_last);
    int errs;
    int first_bad;
    wa_q.delete();
    wd_q.delete();
    hs_cnt = 0; tr_cnt = 0; vo_cnt = 0; vo_cyc = -1; last_we_cyc = -1; stall_seen = 0;
    step();
    dram_addr = base;
    length    = 10'(len);
    valid_in  = 1'b1;
    vi_cyc    = cyc;
    for (int c = 0; c < 6000 && vo_cnt == 0; c++) step();
    repeat (3) step();
    check({tag, "_valid_out_pulses"}, vo_cnt, 1);
    check({tag, "_write_count"}, wa_q.size(), len);
    errs = 0;
    first_bad = -1;
    for (int i = 0; i < wa_q.size() && i < len; i++) begin
      if (wa_q[i] !== 24'(base + 24'(i)) || wd_q[i] !== src[i]) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (errs != 0) $display("  first bad write at element %0d", first_bad);
    check({tag, "_write_errors"}, errs, 0);
    check({tag, "_tile_handshakes"}, hs_cnt, exp_hs);
    if (len == 0) check({tag, "_tile_ready_cycles"}, tr_cnt, 0);
    if (len > 0 && wa_q.size() > 0) check({tag, "_last_addr"}, wa_q[$], exp_last);
    if (len > 0) check({tag, "_done_after_last_write"}, vo_cyc - last_we_cyc, 1);
    if (exp_lat >= 0) check({tag, "_latency"}, vo_cyc - vi_cyc, exp_lat);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  typedef struct {
    string       name;
    logic [23:0] base;
    int          len;
    int          exp_hs;
    int          exp_lat;
    logic [23:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst = 1'b1; valid_in = 1'b0; dram_addr = '0; length = '0;
    tile_valid = 1'b0; mem_ready = 1'b0; tile_in = '0;
    for (int i = 0; i < 1056; i++) src[i] = 8'(i);

    // Always-ready, always-valid latency: one WAIT_TILE per tile, one cycle per
    // element, one DONE; a zero-length transfer goes straight to DONE.
    vecs[0] = '{"len32",    24'h000100,   32,  1,   34, 24'h00011F};
    vecs[1] = '{"len40",    24'h000100,   40,  2,   43, 24'h000127};
    vecs[2] = '{"len0",     24'h000000,    0,  0,    1, 24'h000000};
    vecs[3] = '{"wrap",     24'hFFFFFE,    4,  1,    6, 24'h000001};
    vecs[4] = '{"len1",     24'h000005,    1,  1,    3, 24'h000005};
    vecs[5] = '{"len33",    24'h000010,   33,  2,   36, 24'h000030};
    vecs[6] = '{"len1023",  24'h123456, 1023, 32, 1056, 24'h123854};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_tile_ready", tile_ready, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      run_xfer(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].exp_hs,
               vecs[v].exp_lat, vecs[v].exp_last);
    end

    // Three-cycle stall on element 5 holds address/data and delays completion by 3.
    stall_at = 5; stall_left = 3; hold_chk = 1'b1;
    hold_addr = 24'h000105; hold_data = src[5];
    run_xfer("stall5", 24'h000100, 32, 1, 37, 24'h00011F);
    check("stall5_cycles_seen", stall_seen, 3);
    stall_at = -1; hold_chk = 1'b0;

    // Reset while element 10 is on the bus abandons the transfer.
    wa_q.delete(); wd_q.delete(); hs_cnt = 0;
    step();
    dram_addr = 24'h000200; length = 10'd32; valid_in = 1'b1;
    for (int c = 0; c < 200 && wa_q.size() < 10; c++) step();
    check("midrst_reached_elem10", wa_q.size(), 10);
    rst = 1'b1;
    step();
    check("midrst_mem_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    run_xfer("after_rst", 24'h000300, 32, 1, 34, 24'h00031F);

    // Random transfers with random handshakes and ignored mid-transfer requests.
    ready_pct = 70; tvalid_pct = 60; spurious = 1'b1;
    for (int t = 0; t < 20; t++) begin
      logic [23:0] b;
      int          l;
      for (int i = 0; i < 1056; i++) src[i] = 8'($urandom);
      b = 24'($urandom);
      if (t % 4 == 0) b = 24'hFFFFFF - 24'($urandom_range(0, 20));
      l = (t % 5 == 0) ? $urandom_range(0, 300) : $urandom_range(0, 70);
      run_xfer("rand", b, l, (l + EC - 1) / EC, -1, 24'(b + 24'(l) - 24'd1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
